data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 105 ++++++++++
 tb/tb_data_memory.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
// M-stage data memory for the pipelined core. Holds DEPTH 32-bit words,
// read combinationally (raw word, no extension) and written on the rising
// clock edge with per-byte lane enables derived from the store width and the
// low address bits. Reset asynchronously clears every word.
// ----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  StoreopM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] WDM,
    output logic [31:0] RDM,
    output logic [3:0]  ByteEnM
);

    // Store width encodings as they arrive from the M stage.
    typedef enum logic [1:0] {
        OP_WORD = 2'b00,
        OP_HALF = 2'b01,
        OP_BYTE = 2'b10,
        OP_RSVD = 2'b11
    } storeOp_e;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d;
    logic [31:0]      wrData;
    logic [31:0]      rdRaw;
    logic [IDX_W-1:0] wordIdx;
    logic             anyWrite;
    storeOp_e         storeOp;

    // Address bits above the word index are deliberately dropped so the
    // address space wraps modulo DEPTH*4 bytes.
    logic unusedAddrBits;
    assign unusedAddrBits = ^ALUoutM[31:IDX_W+2];

    assign wordIdx  = ALUoutM[IDX_W+1:2];
    assign storeOp  = storeOp_e'(StoreopM);
    assign rdRaw    = mem_q[wordIdx];
    assign anyWrite = |ByteEnM;

    // Raw word read with zero latency; forced to zero while reset is held.
    always_comb begin
        RDM = rdRaw;
        if (reset) begin
            RDM = '0;
        end
    end

    // Byte-lane enables. Any encoding outside the three legal widths
    // (the reserved code, or an unknown value) leaves all lanes disabled.
    always_comb begin
        ByteEnM = 4'b0000;
        if (MemWriteM && !reset) begin
            case (storeOp)
                OP_WORD: ByteEnM = 4'b1111;
                OP_HALF: ByteEnM = ALUoutM[1] ? 4'b1100 : 4'b0011;
                OP_BYTE: ByteEnM = 4'b0001 << ALUoutM[1:0];
                default: ByteEnM = 4'b0000;
            endcase
        end
    end

    // Replicate the right-aligned store data across the word so every lane
    // that may be enabled already sees its own bytes.
    always_comb begin
        wrData = WDM;
        case (storeOp)
            OP_WORD: wrData = WDM;
            OP_HALF: wrData = {WDM[15:0], WDM[15:0]};
            OP_BYTE: wrData = {4{WDM[7:0]}};
            default: wrData = WDM;
        endcase
    end

    // Merge the enabled lanes of the new data over the currently stored
    // word; disabled lanes keep their old contents.
    always_comb begin
        mem_d = rdRaw;
        for (int b = 0; b < 4; b++) begin
            if (ByteEnM[b]) begin
                mem_d[8*b +: 8] = wrData[8*b +: 8];
            end
        end
    end

    // One register per word: async clear, otherwise capture the merged word
    // when this word is addressed and at least one lane is enabled.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mem_q[w] <= '0;
            end else if (anyWrite && (wordIdx == IDX_W'(w))) begin
                mem_q[w] <= mem_d;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
// Self-checking bench for data_memory. Expected read data is pushed to a
// scoreboard queue when a read is driven and popped when RDM is sampled.
// A reference byte model tracks memory contents for the random phase.
// ----------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_data_memory;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  StoreopM;
    logic [31:0] ALUoutM;
    logic [31:0] WDM;
    logic [31:0] RDM;
    logic [3:0]  ByteEnM;

    int          errorCount = 0;
    int          checkCount = 0;
    logic [31:0] sbQueue [$];
    logic [31:0] model [4096];

    data_memory #(.DEPTH(4096), .IDX_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWriteM (MemWriteM),
        .StoreopM  (StoreopM),
        .ALUoutM   (ALUoutM),
        .WDM       (WDM),
        .RDM       (RDM),
        .ByteEnM   (ByteEnM)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Expected lane enables from the store width table.
    function automatic logic [3:0] refByteEn(input logic [1:0] op, input logic [31:0] addr);
        case (op)
            2'b00:   return 4'hF;
            2'b01:   return (addr[1] == 1'b0) ? 4'h3 : 4'hC;
            2'b10: begin
                case (addr[1:0])
                    2'd0:    return 4'h1;
                    2'd1:    return 4'h2;
                    2'd2:    return 4'h4;
                    default: return 4'h8;
                endcase
            end
            default: return 4'h0;
        endcase
    endfunction

    // Apply one store to the reference model.
    task automatic modelStore(input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wd);
        logic [3:0]  be;
        logic [11:0] idx;
        logic [7:0]  src;
        be  = refByteEn(op, addr);
        idx = addr[13:2];
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (op == 2'b00)      src = wd[8*i +: 8];
                else if (op == 2'b01) src = (i % 2 == 0) ? wd[7:0] : wd[15:8];
                else                  src = wd[7:0];
                model[idx][8*i +: 8] = src;
            end
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4096; i++) model[i] = '0;
    endtask

    // Drive one store for a full cycle (call just after a falling edge).
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] expBe, input bit doCheck);
        MemWriteM = 1'b1;
        StoreopM  = op;
        ALUoutM   = addr;
        WDM       = wd;
        #1;
        if (doCheck) checkOutput({tag, ".be"}, {28'h0, ByteEnM}, {28'h0, expBe});
        @(posedge clk);
        modelStore(op, addr, wd);
        @(negedge clk);
        MemWriteM = 1'b0;
    endtask

    // Read a word: expected value goes into the scoreboard, then RDM is
    // sampled and compared against the popped entry.
    task automatic readCheck(input string tag, input logic [31:0] addr,
                             input logic [31:0] expected);
        logic [31:0] exp;
        sbQueue.push_back(expected);
        MemWriteM = 1'b0;
        ALUoutM   = addr;
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput({tag, ".sbempty"}, 32'h1, 32'h0);
        end else begin
            exp = sbQueue.pop_front();
            checkOutput(tag, RDM, exp);
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  op;

        reset     = 1'b1;
        MemWriteM = 1'b1;
        StoreopM  = 2'b00;
        ALUoutM   = 32'h10;
        WDM       = 32'h1234_5678;
        clearModel();
        $display("[TB] start");

        // Reset state: outputs quiet even with a store requested.
        #12;
        checkOutput("reset.rdm", RDM, 32'h0);
        checkOutput("reset.be", {28'h0, ByteEnM}, 32'h0);
        @(negedge clk);
        MemWriteM = 1'b0;
        reset     = 1'b0;

        // sw round trip, read at aligned and misaligned byte of the word.
        applyStimulus("sw10", 2'b00, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        readCheck("sw10.rd10", 32'h10, 32'hDEADBEEF);
        readCheck("sw10.rd13", 32'h13, 32'hDEADBEEF);
        @(negedge clk);

        // Half then byte merge, back to back.
        applyStimulus("sh12", 2'b01, 32'h12, 32'h0000_1234, 4'hC, 1'b1);
        applyStimulus("sb10", 2'b10, 32'h10, 32'h0000_00AA, 4'h1, 1'b1);
        readCheck("merge.rd10", 32'h10, 32'h1234BEAA);
        @(negedge clk);

        // Same-cycle read/write: old value before the edge, new after.
        MemWriteM = 1'b1;
        StoreopM  = 2'b00;
        ALUoutM   = 32'h20;
        WDM       = 32'h1111_1111;
        #1;
        checkOutput("hazard.before", RDM, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("hazard.after", RDM, 32'h1111_1111);
        modelStore(2'b00, 32'h20, 32'h1111_1111);
        @(negedge clk);
        MemWriteM = 1'b0;

        // Wrap-around and reserved opcode.
        applyStimulus("wrap", 2'b00, 32'h0000_4004, 32'hCAFEF00D, 4'hF, 1'b1);
        readCheck("wrap.rd4", 32'h4, 32'hCAFEF00D);
        @(negedge clk);
        applyStimulus("rsvd", 2'b11, 32'h4, 32'h0, 4'h0, 1'b1);
        readCheck("rsvd.rd4", 32'h4, 32'hCAFEF00D);
        @(negedge clk);

        // Misaligned sw writes the containing word.
        applyStimulus("swmis", 2'b00, 32'h33, 32'hA1B2C3D4, 4'hF, 1'b1);
        readCheck("swmis.rd30", 32'h30, 32'hA1B2C3D4);
        @(negedge clk);

        // Random stores checked against the reference model.
        for (int n = 0; n < 60; n++) begin
            op   = 2'($urandom_range(0, 3));
            addr = {$urandom_range(0, 3) == 0 ? 18'h3 : 18'h0, 6'h0,
                    6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            data = $urandom;
            applyStimulus("rnd", op, addr, data, refByteEn(op, addr), 1'b1);
        end
        for (int n = 0; n < 16; n++) begin
            addr = 32'(n * 4);
            readCheck("rnd.rd", addr, model[addr[13:2]]);
        end
        @(negedge clk);

        // Fill the whole memory with nonzero data.
        for (int i = 0; i < 4096; i++) begin
            applyStimulus("fill", 2'b00, 32'(i * 4), 32'hA500_0000 | 32'(i) | 32'h1_0000,
                          4'hF, 1'b0);
        end
        readCheck("fill.rd0", 32'h0, 32'hA501_0000);
        readCheck("fill.rd3ffc", 32'h3FFC, 32'hA501_0FFF);
        @(negedge clk);

        // Short reset pulse between edges.
        ALUoutM = 32'h3FFC;
        #2;
        reset = 1'b1;
        #0.5;
        checkOutput("pulse.rdm", RDM, 32'h0);
        #0.5;
        reset = 1'b0;
        clearModel();
        @(negedge clk);
        readCheck("pulse.rd0", 32'h0, 32'h0);
        readCheck("pulse.rd3ffc", 32'h3FFC, 32'h0);
        for (int n = 0; n < 12; n++) begin
            addr = 32'($urandom_range(0, 4095) * 4);
            readCheck("pulse.rnd", addr, 32'h0);
        end
        @(negedge clk);

        // Preload 0x8, then reset held across a store edge.
        applyStimulus("pre8", 2'b00, 32'h8, 32'h5555_AAAA, 4'hF, 1'b1);
        MemWriteM = 1'b1;
        StoreopM  = 2'b00;
        ALUoutM   = 32'h8;
        WDM       = 32'hFFFF_FFFF;
        reset     = 1'b1;
        clearModel();
        #1;
        checkOutput("rststore.be", {28'h0, ByteEnM}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        MemWriteM = 1'b0;
        reset     = 1'b0;
        readCheck("rststore.rd8", 32'h8, 32'h0);
        @(negedge clk);

        // First store after reset behaves normally.
        applyStimulus("post", 2'b10, 32'h9, 32'h0000_007E, 4'h2, 1'b1);
        readCheck("post.rd8", 32'h8, 32'h0000_7E00);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
